// File: rtl/recirc_pkg.sv
// recirc_pkg: shared definitions for the recirculator flow-control slice.
//   - state_e      : FSM state encoding (also driven onto the state port)
//   - LANES/DATA_W : recirculator geometry
//   - threshold reset defaults for the lane FIFOs
package recirc_pkg;

   localparam int LANES  = 4;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_e;

   localparam logic [3:0] AF_DEFAULT_C = 4'd6;
   localparam logic [3:0] AE_DEFAULT_C = 4'd1;

endpackage : recirc_pkg

// File: rtl/recirc_idle_timer.sv
// recirc_idle_timer: saturating counter of consecutive all-empty cycles.
//   clk, reset_L : clock / asynchronous active-low reset
//   clr          : clear the count (has priority over inc)
//   inc          : this cycle counts as an all-empty cycle
//   done         : this all-empty cycle is the last one needed (count
//                  already at IDLE_CYCLES-1), so the FSM may drop to IDLE
module recirc_idle_timer #(
   parameter int IDLE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset_L,
   input  logic clr,
   input  logic inc,
   output logic done
);

   localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] SAT_C  = CNT_W'(IDLE_CYCLES);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // next count: clear, saturating increment, or hold
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != SAT_C)) begin
         cnt_d = cnt_q + ONE_C;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = inc && (cnt_q == LAST_C);

endmodule : recirc_idle_timer

// File: rtl/recirc_flow_ctrl.sv
// recirc_flow_ctrl: control FSM for the 4-lane recirculator.
//   Inputs : clk, reset_L (async active-low), init, umbral_AF_in/AE_in,
//            fifo_empty / fifo_almost_full / fifo_error (per lane)
//   Outputs: selector_IDLE (1 = forward to lanes 4-7), pause (per lane),
//            umbral_AF_out/AE_out (active FIFO thresholds), state,
//            idle_out, error_out. All outputs are registered and show the
//            state entered at the same edge.
module recirc_flow_ctrl
   import recirc_pkg::*;
#(
   parameter int                     UMBRAL_W    = 4,
   parameter logic [UMBRAL_W-1:0]    AF_DEFAULT  = UMBRAL_W'(AF_DEFAULT_C),
   parameter logic [UMBRAL_W-1:0]    AE_DEFAULT  = UMBRAL_W'(AE_DEFAULT_C),
   parameter int                     IDLE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                reset_L,
   input  logic                init,
   input  logic [UMBRAL_W-1:0] umbral_AF_in,
   input  logic [UMBRAL_W-1:0] umbral_AE_in,
   input  logic [LANES-1:0]    fifo_empty,
   input  logic [LANES-1:0]    fifo_almost_full,
   input  logic [LANES-1:0]    fifo_error,
   output logic                selector_IDLE,
   output logic [LANES-1:0]    pause,
   output logic [UMBRAL_W-1:0] umbral_AF_out,
   output logic [UMBRAL_W-1:0] umbral_AE_out,
   output logic [2:0]          state,
   output logic                idle_out,
   output logic                error_out
);

   state_e              state_q, state_d;
   logic                sel_q, sel_d;
   logic [LANES-1:0]    pause_q, pause_d;
   logic [UMBRAL_W-1:0] af_q, af_d, ae_q, ae_d;
   logic                idle_q, idle_d;
   logic                err_q, err_d;

   logic all_empty_s;
   logic timer_clr_s;
   logic timer_inc_s;
   logic timer_done_s;

   assign all_empty_s = (fifo_empty == {LANES{1'b1}});
   // Count only while ACTIVE; any other state or a non-empty cycle restarts it,
   // so the count is always zero on entry to ACTIVE.
   assign timer_inc_s = (state_q == ST_ACTIVE) && all_empty_s;
   assign timer_clr_s = !timer_inc_s;

   recirc_idle_timer #(
      .IDLE_CYCLES (IDLE_CYCLES)
   ) u_idle_timer (
      .clk     (clk),
      .reset_L (reset_L),
      .clr     (timer_clr_s),
      .inc     (timer_inc_s),
      .done    (timer_done_s)
   );

   // next state and threshold loading
   always_comb begin
      state_d = state_q;
      af_d    = af_q;
      ae_d    = ae_q;
      case (state_q)
         ST_RESET: begin
            state_d = ST_INIT;
         end
         ST_INIT: begin
            if (init) begin
               state_d = ST_INIT;
               // an inverted or equal pair would make the FIFO flags meaningless
               if (umbral_AE_in < umbral_AF_in) begin
                  af_d = umbral_AF_in;
                  ae_d = umbral_AE_in;
               end else begin
                  af_d = af_q;
                  ae_d = ae_q;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (|fifo_error) begin
               state_d = ST_ERROR;
            end else if (init) begin
               state_d = ST_INIT;
            end else if (!all_empty_s) begin
               state_d = ST_ACTIVE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (|fifo_error) begin
               state_d = ST_ERROR;
            end else if (init) begin
               state_d = ST_INIT;
            end else if (timer_done_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_ACTIVE;
            end
         end
         ST_ERROR: begin
            state_d = ST_ERROR;
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
   end

   // Moore outputs decoded from the state being entered
   always_comb begin
      sel_d   = 1'b0;
      idle_d  = 1'b0;
      err_d   = 1'b0;
      pause_d = {LANES{1'b1}};
      case (state_d)
         ST_IDLE: begin
            idle_d  = 1'b1;
            pause_d = fifo_almost_full;
         end
         ST_ACTIVE: begin
            sel_d   = 1'b1;
            pause_d = fifo_almost_full;
         end
         ST_ERROR: begin
            err_d   = 1'b1;
         end
         default: begin
            pause_d = {LANES{1'b1}};
         end
      endcase
   end

   // state, threshold and output registers
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q <= ST_RESET;
         sel_q   <= 1'b0;
         pause_q <= {LANES{1'b1}};
         af_q    <= AF_DEFAULT;
         ae_q    <= AE_DEFAULT;
         idle_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         pause_q <= pause_d;
         af_q    <= af_d;
         ae_q    <= ae_d;
         idle_q  <= idle_d;
         err_q   <= err_d;
      end
   end

   assign state         = state_q;
   assign selector_IDLE = sel_q;
   assign pause         = pause_q;
   assign umbral_AF_out = af_q;
   assign umbral_AE_out = ae_q;
   assign idle_out      = idle_q;
   assign error_out     = err_q;

endmodule : recirc_flow_ctrl

// File: doc/recirc_flow_ctrl.md
Name: recirc_flow_ctrl

Overview:
Control FSM that sequences the 4-lane recirculator.
- Generates selector_IDLE, which picks recirculate (lanes 0-3) vs forward (lanes 4-7).
- Holds the almost-full/almost-empty thresholds programmed into the downstream lane FIFOs.
- Issues per-lane pause back-pressure and latches FIFO errors.
- Sits between the lane FIFOs' status flags and the recirculator select input.

Parameters:
- UMBRAL_W, 4, width of the threshold registers (FIFO depth 2**UMBRAL_W).
- AF_DEFAULT, 4'd6, almost-full threshold after reset.
- AE_DEFAULT, 4'd1, almost-empty threshold after reset.
- IDLE_CYCLES, 4, consecutive all-empty cycles required to drop from ACTIVE to IDLE (must be >= 1).

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- reset_L  in  1  asynchronous active-low reset.
- init  in  1  request configuration; thresholds are loaded while high.
- umbral_AF_in  in  UMBRAL_W  almost-full threshold to load.
- umbral_AE_in  in  UMBRAL_W  almost-empty threshold to load.
- fifo_empty  in  4  per-lane FIFO empty flags.
- fifo_almost_full  in  4  per-lane FIFO almost-full flags.
- fifo_error  in  4  per-lane FIFO overflow/underflow flags.
- selector_IDLE  out  1  0 = recirculate, 1 = forward to outputs 4-7.
- pause  out  4  per-lane upstream stall.
- umbral_AF_out  out  UMBRAL_W  active almost-full threshold, to the FIFOs.
- umbral_AE_out  out  UMBRAL_W  active almost-empty threshold, to the FIFOs.
- state  out  3  current state encoding.
- idle_out  out  1  high in IDLE.
- error_out  out  1  high in ERROR.

Behaviour:
- State encoding: RESET=3'd0, INIT=3'd1, IDLE=3'd2, ACTIVE=3'd3, ERROR=3'd4. Other codes are illegal and go to RESET on the next edge.
- Asynchronous reset (reset_L=0):
  - state=RESET; selector_IDLE=0; pause=4'hF; idle_out=0; error_out=0.
  - umbral_AF_out=AF_DEFAULT; umbral_AE_out=AE_DEFAULT; idle counter=0.
- All outputs are registered (Moore) and reflect the state entered at the same edge.
- Transition priority from IDLE and ACTIVE: any fifo_error -> ERROR, else init=1 -> INIT, else the normal rules below.
- RESET: first edge with reset_L=1 -> INIT.
- INIT:
  - Each edge with init=1 loads both thresholds, but only if umbral_AE_in < umbral_AF_in.
  - An invalid pair is ignored and the previous values are held.
  - init=0 -> IDLE. Exiting INIT does not require a prior load.
  - pause=4'hF; selector_IDLE=0.
- IDLE:
  - idle_out=1; selector_IDLE=0; pause=fifo_almost_full, registered with 1-cycle latency.
  - Any fifo_empty bit = 0 -> ACTIVE. The idle counter is cleared on entry to ACTIVE.
- ACTIVE:
  - selector_IDLE=1; idle_out=0; pause=fifo_almost_full, registered.
  - Idle counter: increments on cycles with fifo_empty=4'hF and clears on any other cycle. It saturates at IDLE_CYCLES.
  - The edge where the counter equals IDLE_CYCLES-1 and fifo_empty=4'hF goes to IDLE.
- ERROR:
  - error_out=1; selector_IDLE=0; pause=4'hF.
  - Sticky: only reset_L exits. init and fifo_error are ignored.
- Simultaneous events:
  - fifo_error and init in the same cycle -> ERROR.
  - Data arriving on the same edge ACTIVE->IDLE would fire: counter clears, and state stays ACTIVE.
- Reset mid-operation: immediate asynchronous return to reset values. Programmed thresholds are lost and the defaults are restored.
- Counter width: $clog2(IDLE_CYCLES+1).

Decomposition:
- Shared package recirc_pkg holds:
  - the state localparams (RESET..ERROR);
  - LANES=4 and DATA_W=8;
  - threshold default constants.
- One sub-module is natural: recirc_idle_timer (saturating consecutive-empty counter with clear, exposing a done flag). The FSM, threshold registers and pause logic stay in the top module.

Test Plan:
- Reset release: hold reset_L=0 for 3 cycles, then release -> state=0, pause=4'hF, AF=6, AE=1 during reset; state=1 one edge after release.
- Init load: init=1 with AF_in=4'd7, AE_in=4'd2, then init=0 -> umbral_AF_out=7 and umbral_AE_out=2 one edge after load; state=2 one edge after init drops.
- Invalid init: init=1 with AF_in=3, AE_in=5 -> thresholds unchanged at 6/1.
- Traffic cycle: in IDLE drive fifo_empty=4'b1011 -> state=3 and selector_IDLE=1 next edge. Then fifo_empty=4'hF for 4 cycles -> state=2 after the 4th edge. A single nonempty cycle at count 2 restarts the count.
- Back-pressure: in ACTIVE drive fifo_almost_full=4'b0100 -> pause=4'b0100 one cycle later.
- Error: in ACTIVE raise fifo_error[1] together with init=1 -> state=4, error_out=1, selector_IDLE=0, pause=4'hF; remains in ERROR for 10 cycles until reset_L=0.
